// File: rtl/tx_serializer.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first payload, stop bit.
// Define TX_PARITY_EN to insert an even-parity bit between payload and stop.
module tx_serializer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              PARALLEL_LOAD,
  input  logic              Tx_DATA,
  output logic              DOUT,
  output logic              BUSY,
  output logic              Tx_DONE
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end_c;
`ifdef TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign bit_end_c = (cnt_q == CNT_LAST);

  // Next-state and registered-output logic; every bit lasts BAUD_DIV cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    hold_d   = PARALLEL_LOAD ? DATA_IN : hold_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != S_IDLE) begin
      cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        dout_d = 1'b1;
        busy_d = 1'b0;
        // hold_d already reflects a same-cycle load, so that word is sent
        if (Tx_DATA) begin
          state_d  = S_START;
          shift_d  = hold_d;
          cnt_d    = '0;
          idx_d    = '0;
          dout_d   = 1'b0;
          busy_d   = 1'b1;
`ifdef TX_PARITY_EN
          parity_d = ^hold_d;
`endif
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          dout_d  = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (idx_q == IDX_LAST) begin
`ifdef TX_PARITY_EN
            state_d = S_PARITY;
            dout_d  = parity_q;
`else
            state_d = S_STOP;
            dout_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            dout_d  = shift_d[0];
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          dout_d  = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_c) begin
          state_d = S_IDLE;
          dout_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        dout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      shift_q  <= '0;
      dout_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign DOUT    = dout_q;
  assign BUSY    = busy_q;
  assign Tx_DONE = done_q;

endmodule
